logic_gate_pipe: RTL and testbench

//  Parametrised, pipelined multi-input bitwise gate unit; next generation of the team's

---
 rtl/logic_gate_pkg.sv | 55 +++++
 rtl/logic_gate_reduce.sv | 45 ++++
 rtl/logic_gate_pipe.sv | 89 ++++++++
 tb/tb_logic_gate_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic_gate_pipe unit.
//   OP_*        3-bit op codes sampled alongside the operands
//   OP_W/CNT_W  op-code and result-counter widths
//   gate_reduce reference reduction over up to MAX_IN operands of up to MAX_W bits,
//               usable by models that work on fixed-size operand arrays
package logic_gate_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MAX_W  = 32;
  localparam int unsigned MAX_IN = 8;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_PASS = 3'd6;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd7;

  // Only the first num_in entries of operands take part in the reduction.
  function automatic logic [MAX_W-1:0] gate_reduce(
    input logic [OP_W-1:0]  op,
    input logic [MAX_W-1:0] operands [MAX_IN],
    input int unsigned      num_in
  );
    logic [MAX_W-1:0] acc_and;
    logic [MAX_W-1:0] acc_or;
    logic [MAX_W-1:0] acc_xor;
    logic [MAX_W-1:0] res;
    acc_and = operands[0];
    acc_or  = operands[0];
    acc_xor = operands[0];
    for (int unsigned k = 1; k < MAX_IN; k++) begin
      if (k < num_in) begin
        acc_and = acc_and & operands[k];
        acc_or  = acc_or  | operands[k];
        acc_xor = acc_xor ^ operands[k];
      end
    end
    case (op)
      OP_AND:  res = acc_and;
      OP_OR:   res = acc_or;
      OP_XOR:  res = acc_xor;
      OP_NAND: res = ~acc_and;
      OP_NOR:  res = ~acc_or;
      OP_XNOR: res = ~acc_xor;
      OP_PASS: res = operands[0];
      default: res = ~operands[0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_gate_reduce.sv
// Combinational NUM_IN x WIDTH bitwise reduction selected by op.
//   data   in   NUM_IN*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
//   op     in   OP_W          op code (AND/OR/XOR/NAND/NOR/XNOR/PASS/NOT)
//   result out  WIDTH         reduced value
module logic_gate_reduce
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [OP_W-1:0]         op,
  output logic [WIDTH-1:0]        result
);

  logic [WIDTH-1:0] acc_and;
  logic [WIDTH-1:0] acc_or;
  logic [WIDTH-1:0] acc_xor;

  always_comb begin
    acc_and = data[WIDTH-1:0];
    acc_or  = data[WIDTH-1:0];
    acc_xor = data[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      acc_and = acc_and & data[k*WIDTH +: WIDTH];
      acc_or  = acc_or  | data[k*WIDTH +: WIDTH];
      acc_xor = acc_xor ^ data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = acc_and;
      OP_OR:   result = acc_or;
      OP_XOR:  result = acc_xor;
      OP_NAND: result = ~acc_and;
      OP_NOR:  result = ~acc_or;
      OP_XNOR: result = ~acc_xor;
      OP_PASS: result = data[WIDTH-1:0];
      OP_NOT:  result = ~data[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined multi-input bitwise gate unit with valid/ready handshakes on both sides.
// Operands are reduced combinationally, registered in stage 1 and delayed through
// DEPTH stages; the last stage drives the outputs directly.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand-side handshake; in_data (NUM_IN*WIDTH), in_op (3)
//   out_valid/out_ready result-side handshake; out_data (WIDTH), out_op (3)
//   res_cnt             saturating count of result transfers
// Build option: define LOGIC_GATE_PIPE_CNT_EN to build the result counter; otherwise
// res_cnt reads constant zero.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]         in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [OP_W-1:0]         out_op,
  output logic [CNT_W-1:0]        res_cnt
);

  logic [WIDTH-1:0] reduced;
  logic             adv;
  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [OP_W-1:0]  op_q  [DEPTH];

  logic_gate_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .data   (in_data),
    .op     (in_op),
    .result (reduced)
  );

  // Single global stall: the whole pipe moves only when the last stage is empty
  // or being drained, so interior bubbles are never collapsed.
  assign adv      = !vld_q[DEPTH-1] || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        op_q[i]  <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      dat_q[0] <= reduced;
      op_q[0]  <= in_op;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
        op_q[i]  <= op_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
  assign out_op    = op_q[DEPTH-1];

`ifdef LOGIC_GATE_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign res_cnt = cnt_q;
`else
  assign res_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic [15:0] idat = '0;
  logic [2:0]  iop = '0;
  logic        ordy = 1'b1;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_op;
  logic [15:0] res_cnt;

  logic        iv3 = 1'b0;
  logic [23:0] idat3 = '0;
  logic [2:0]  iop3 = '0;
  logic        in_ready3, out_valid3;
  logic [7:0]  out_data3;
  logic [2:0]  out_op3;
  logic [15:0] res_cnt3;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_d [$];
  logic [2:0] exp_o [$];
  int         out_n;
  logic       xfer;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(in_ready),
    .in_data(idat), .in_op(iop), .out_valid(out_valid), .out_ready(ordy),
    .out_data(out_data), .out_op(out_op), .res_cnt(res_cnt)
  );

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .DEPTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(in_ready3),
    .in_data(idat3), .in_op(iop3), .out_valid(out_valid3), .out_ready(1'b1),
    .out_data(out_data3), .out_op(out_op3), .res_cnt(res_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [15:0] d);
    logic [MAX_W-1:0] ops [MAX_IN];
    logic [MAX_W-1:0] r;
    for (int k = 0; k < int'(MAX_IN); k++) ops[k] = '0;
    ops[0] = {24'h0, d[7:0]};
    ops[1] = {24'h0, d[15:8]};
    r = gate_reduce(op, ops, 2);
    return r[7:0];
  endfunction

  // One clock: score accepts/transfers just before the edge, then advance to edge+1.
  task automatic tick();
    #1;
    xfer = 1'b0;
    if (iv && in_ready) begin
      exp_d.push_back(model(iop, idat));
      exp_o.push_back(iop);
    end
    if (out_valid && ordy) begin
      xfer = 1'b1;
      out_n++;
      if (exp_d.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else begin
        chk("sb_data", {24'h0, out_data}, {24'h0, exp_d.pop_front()});
        chk("sb_op", {29'h0, out_op}, {29'h0, exp_o.pop_front()});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] sweep_exp [8];
  logic [7:0] held;
  int first_out, last_out, cnt_expect;

  initial begin
    sweep_exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};

    // Reset held with traffic offered
    iv = 1'b1; idat = 16'h3CF0; iop = OP_OR; ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_data", {24'h0, out_data}, 32'd0);
    chk("rst_out_op", {29'h0, out_op}, 32'd0);
    chk("rst_res_cnt", {16'h0, res_cnt}, 32'd0);
    iv = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Op sweep, a=F0 b=3C, exact two-cycle latency
    for (int op = 0; op < 8; op++) begin
      iv = 1'b1; idat = 16'h3CF0; iop = 3'(op);
      #1 chk("sweep_in_ready", {31'h0, in_ready}, 32'd1);
      @(posedge clk); #1;
      iv = 1'b0;
      chk("sweep_lat1_valid", {31'h0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("sweep_valid", {31'h0, out_valid}, 32'd1);
      chk("sweep_data", {24'h0, out_data}, {24'h0, sweep_exp[op]});
      chk("sweep_op", {29'h0, out_op}, op);
      @(posedge clk); #1;
      chk("sweep_drain", {31'h0, out_valid}, 32'd0);
    end

    // Three-operand instance: FF,0F,05
    idat3 = 24'h050FFF;
    iv3 = 1'b1; iop3 = OP_XOR;
    @(posedge clk); #1;
    iop3 = OP_AND;
    @(posedge clk); #1;
    iv3 = 1'b0;
    chk("n3_xor_valid", {31'h0, out_valid3}, 32'd1);
    chk("n3_xor", {24'h0, out_data3}, 32'h0000_00F5);
    @(posedge clk); #1;
    chk("n3_and_valid", {31'h0, out_valid3}, 32'd1);
    chk("n3_and", {24'h0, out_data3}, 32'h0000_0005);

    // Backpressure: 4 ops, sink stalled 3 cycles once the first result shows
    out_n = 0;
    begin
      logic [15:0] bp_d [4];
      logic [2:0]  bp_o [4];
      int idx;
      int stalls;
      bp_d = '{16'h3CF0, 16'hAA55, 16'h0FF0, 16'h1234};
      bp_o = '{OP_XOR, OP_NAND, OP_PASS, OP_OR};
      idx = 0; stalls = 0;
      ordy = 1'b0;
      for (int c = 0; c < 40 && out_n < 4; c++) begin
        iv = (idx < 4);
        if (idx < 4) begin idat = bp_d[idx]; iop = bp_o[idx]; end
        if (out_valid && stalls < 3) begin
          if (stalls == 0) held = out_data;
          #1;
          chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
          chk("bp_held", {24'h0, out_data}, {24'h0, held});
          stalls++;
          if (stalls == 3) ordy = 1'b1;
          #0;
        end
        #1;
        if (iv && in_ready) idx++;
        tick();
      end
      iv = 1'b0;
      chk("bp_count", out_n, 32'd4);
      chk("bp_stalls", stalls, 32'd3);
      chk("bp_queue_empty", exp_d.size(), 32'd0);
    end

    // Full rate: 20 back-to-back accepts, one result per cycle
    out_n = 0; first_out = -1; last_out = -1;
    ordy = 1'b1;
    for (int c = 0; c < 26; c++) begin
      iv = (c < 20);
      idat = 16'(c * 16'h1357 + 16'h00A5);
      iop = 3'(c);
      tick();
      if (xfer) begin
        if (first_out < 0) first_out = c;
        last_out = c;
      end
    end
    iv = 1'b0;
    chk("fr_count", out_n, 32'd20);
    chk("fr_first", first_out, 32'd2);
    chk("fr_last", last_out, 32'd21);

    // Mid-stream reset: in-flight results are discarded
    iv = 1'b1; idat = 16'hFF00; iop = OP_OR;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mr_pre_valid", {31'h0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_async_drop", {31'h0, out_valid}, 32'd0);
    chk("mr_res_cnt", {16'h0, res_cnt}, 32'd0);
    exp_d.delete(); exp_o.delete();
    iv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_n = 0;
    for (int c = 0; c < 4; c++) tick();
    chk("mr_no_ghost", out_n, 32'd0);

    // Result counter: 5 transfers after reset
    for (int c = 0; c < 9; c++) begin
      iv = (c < 5); idat = 16'h0F0F; iop = OP_XNOR;
      tick();
    end
    iv = 1'b0;
    chk("cnt_xfers", out_n, 32'd5);
`ifdef LOGIC_GATE_PIPE_CNT_EN
    cnt_expect = 5;
`else
    cnt_expect = 0;
`endif
    chk("cnt_five", {16'h0, res_cnt}, cnt_expect);

`ifdef LOGIC_GATE_PIPE_CNT_EN
    force dut.cnt_q = 16'hFFFD;
    #1;
    release dut.cnt_q;
    for (int c = 0; c < 8; c++) begin
      iv = (c < 5);
      tick();
    end
    iv = 1'b0;
    chk("cnt_saturate", {16'h0, res_cnt}, 32'h0000_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
